// File: rtl/t_sram_arbiter.sv
// Single-port SRAM scheduler: level-held reads, FIFO-buffered writes, one access per cycle.
// Optional read-after-write address hazard check: define T_SRAM_ARB_RAW_CHECK_EN.
module t_sram_arbiter #(
    parameter int WORD_W     = 64,
    parameter int HEADER_BIT = 4,
    parameter int T_PER_WORD = 4,
    parameter int ADDR_W     = 8,
    parameter int TSIZE_W    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TSIZE_W-1:0]           i_t_size,
    input  logic                         i_rd_req,
    output logic [WORD_W-1:0]            o_rd_data,
    input  logic                         i_wr_send,
    input  logic [WORD_W-1:0]            i_wr_data,
    input  logic                         i_rst_addr,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic [WORD_W-HEADER_BIT-1:0] o_mem_wdata,
    input  logic [WORD_W-HEADER_BIT-1:0] i_mem_rdata,
    output logic                         o_busy,
    output logic                         o_overflow,
    output logic [1:0]                   rd_state
);
    localparam int PW = WORD_W - HEADER_BIT;
    localparam int CW = HEADER_BIT - 1;
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        RD_RESP = 2'd3
    } rd_state_t;

    rd_state_t         state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]     fifo_data [FIFO_DEPTH];
    logic [IW-1:0]     head;
    logic [IW-1:0]     tail;
    logic [NW-1:0]     fifo_cnt;
    logic              rst_pend;
    logic              rd_last;

    logic [31:0]       last_idx;
    logic [CW-1:0]     last_cnt;
    logic              hazard;
    logic              pending;
    logic              rd_elig;
    logic              wr_gnt;
    logic              rd_gnt;
    logic              apply_rst;
    logic              enq;
    logic              fifo_full;
    logic              near_full;
    logic [ADDR_W-1:0] wr_base;
    logic              unused_hdr;

    // Index of the final word of a T row and the group count it carries (0 = full word).
    assign last_idx  = (32'(i_t_size) + 32'(T_PER_WORD) - 32'd1) / 32'(T_PER_WORD) - 32'd1;
    assign last_cnt  = CW'(32'(i_t_size) % 32'(T_PER_WORD));
    assign fifo_full = (32'(fifo_cnt) == 32'(FIFO_DEPTH));
    assign near_full = (32'(fifo_cnt) >= 32'(FIFO_DEPTH - 1));
    assign unused_hdr = ^i_wr_data[WORD_W-1:PW];

`ifdef T_SRAM_ARB_RAW_CHECK_EN
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i < int'(fifo_cnt) && fifo_addr[head + IW'(i)] == rd_ptr) hazard = 1'b1;
        end
    end
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        pending   = rst_pend | i_rst_addr;
        rd_elig   = (state == IDLE) && i_rd_req && !pending && !hazard;
        wr_gnt    = (fifo_cnt != '0) && (near_full || !rd_elig);
        rd_gnt    = rd_elig && !wr_gnt;
        apply_rst = pending && (fifo_cnt == '0) && (state == IDLE);
        enq       = i_wr_send && (!fifo_full || wr_gnt);
        // A write enqueued in the cycle the pointers return to 0 already lands at address 0.
        wr_base   = apply_rst ? '0 : wr_ptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            head        <= '0;
            tail        <= '0;
            fifo_cnt    <= '0;
            rst_pend    <= 1'b0;
            rd_last     <= 1'b0;
            o_rd_data   <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_overflow  <= 1'b0;
        end else begin
            o_mem_en    <= wr_gnt | rd_gnt;
            o_mem_we    <= wr_gnt;
            o_mem_addr  <= wr_gnt ? fifo_addr[head] : (rd_gnt ? rd_ptr : '0);
            o_mem_wdata <= wr_gnt ? fifo_data[head] : '0;
            o_rd_data   <= '0;

            case (state)
                IDLE: begin
                    if (rd_gnt) begin
                        state   <= RD_CMD;
                        rd_last <= (32'(rd_ptr) == last_idx);
                    end
                end
                RD_CMD:  state <= RD_DATA;
                RD_DATA: begin
                    state     <= RD_RESP;
                    o_rd_data <= {1'b1, (rd_last ? last_cnt : CW'(0)), i_mem_rdata};
                end
                RD_RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (apply_rst)   rd_ptr <= '0;
            else if (rd_gnt) rd_ptr <= (32'(rd_ptr) == last_idx) ? '0 : rd_ptr + ADDR_W'(1);

            if (enq) wr_ptr <= (32'(wr_base) == last_idx) ? '0 : wr_base + ADDR_W'(1);
            else     wr_ptr <= wr_base;

            head     <= head + IW'(wr_gnt);
            tail     <= tail + IW'(enq);
            fifo_cnt <= fifo_cnt + NW'(enq) - NW'(wr_gnt);

            if (i_wr_send && !enq) o_overflow <= 1'b1;
            rst_pend <= pending && !apply_rst;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by fifo_cnt.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[tail] <= wr_base;
            fifo_data[tail] <= i_wr_data[PW-1:0];
        end
    end

    assign o_busy   = (fifo_cnt != '0) || (state != IDLE) || rst_pend;
    assign rd_state = state;

endmodule

// File: tb/tb_t_sram_arbiter.sv
// Self-checking bench for t_sram_arbiter: cycle vector tables plus directed corner sequences.
module tb_t_sram_arbiter;
    localparam int WORD_W = 64;
    localparam int PW     = 60;

`ifdef T_SRAM_ARB_RAW_CHECK_EN
    localparam logic HZ_FIRST_WE = 1'b1;
    localparam int   HZ_RESP     = 5;
    localparam logic [7:0] HZ_PAY_K = 8'h77;
`else
    localparam logic HZ_FIRST_WE = 1'b0;
    localparam int   HZ_RESP     = 4;
    localparam logic [7:0] HZ_PAY_K = 8'h00;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        t_size;
    logic              rd_req;
    logic [WORD_W-1:0] rd_data;
    logic              wr_send;
    logic [WORD_W-1:0] wr_data;
    logic              rst_addr;
    logic              mem_en;
    logic              mem_we;
    logic [7:0]        mem_addr;
    logic [PW-1:0]     mem_wdata;
    logic [PW-1:0]     mem_rdata;
    logic              busy;
    logic              overflow;
    logic [1:0]        rd_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t_sram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_t_size    (t_size),
        .i_rd_req    (rd_req),
        .o_rd_data   (rd_data),
        .i_wr_send   (wr_send),
        .i_wr_data   (wr_data),
        .i_rst_addr  (rst_addr),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_overflow  (overflow),
        .rd_state    (rd_state)
    );

    function automatic logic [PW-1:0] pat(input logic [7:0] a);
        return {52'h5C0FFEE000000, a};
    endfunction

    function automatic logic [PW-1:0] wpay(input logic [7:0] k);
        return {52'h0BEEF00000000, k};
    endfunction

    function automatic logic [WORD_W-1:0] wdat(input logic [7:0] k);
        return {4'hF, wpay(k)};
    endfunction

    function automatic logic [WORD_W-1:0] rdv(input logic [2:0] cnt, input logic [PW-1:0] pay);
        return {1'b1, cnt, pay};
    endfunction

    // SRAM model: one-cycle read latency, unwritten words read back as pat(addr).
    logic [PW-1:0] mem [int];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[int'(mem_addr)] = mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : pat(mem_addr);
    end

    typedef struct {
        logic              fresh;
        logic [9:0]        ts;
        logic              rd;
        logic              wr;
        logic [WORD_W-1:0] wd;
        logic              en;
        logic              we;
        logic [7:0]        addr;
        logic [PW-1:0]     wdat_e;
        logic [WORD_W-1:0] rd_e;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fresh, input logic [9:0] ts, input logic rd,
                                input logic wr, input logic [WORD_W-1:0] wd, input logic en,
                                input logic we, input logic [7:0] addr,
                                input logic [PW-1:0] wdat_e, input logic [WORD_W-1:0] rd_e);
        vec_t v;
        v.fresh = fresh; v.ts = ts; v.rd = rd; v.wr = wr; v.wd = wd;
        v.en = en; v.we = we; v.addr = addr; v.wdat_e = wdat_e; v.rd_e = rd_e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_cmd(input string name, input logic en, input logic we, input logic [7:0] a);
        chk({name, " en"}, 64'(mem_en), 64'(en));
        if (en) begin
            chk({name, " we"}, 64'(mem_we), 64'(we));
            chk({name, " addr"}, 64'(mem_addr), 64'(a));
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " rd_data"}, rd_data, 64'd0);
        chk({name, " mem_en"}, 64'(mem_en), 64'd0);
        chk({name, " mem_we"}, 64'(mem_we), 64'd0);
        chk({name, " mem_addr"}, 64'(mem_addr), 64'd0);
        chk({name, " mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " overflow"}, 64'(overflow), 64'd0);
        chk({name, " rd_state"}, 64'(rd_state), 64'd0);
    endtask

    task automatic idle_inputs();
        rd_req = 1'b0; wr_send = 1'b0; wr_data = '0; rst_addr = 1'b0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released: cycle 0 starts here.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        t_size = 10'd10;
        idle_inputs();
        #12;
        chk_zero("reset");
        next_cycle();

        // Read timing, t_size=10: 3 words, last word carries count 2.
        vecs.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, rdv(3'd0, pat(8'd0))));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, rdv(3'd0, pat(8'd1))));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, rdv(3'd2, pat(8'd2))));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 10, 1, 0, 0, 1, 0, 0, 0, 0));
        // Write drain, t_size=16: four words to addresses 0..3, header bits stripped.
        vecs.push_back(mk(1, 16, 0, 1, wdat(8'd0), 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16, 0, 1, wdat(8'd1), 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16, 0, 1, wdat(8'd2), 1, 1, 0, wpay(8'd0), 0));
        vecs.push_back(mk(0, 16, 0, 1, wdat(8'd3), 1, 1, 1, wpay(8'd1), 0));
        vecs.push_back(mk(0, 16, 0, 0, 0, 1, 1, 2, wpay(8'd2), 0));
        vecs.push_back(mk(0, 16, 0, 0, 0, 1, 1, 3, wpay(8'd3), 0));
        vecs.push_back(mk(0, 16, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].fresh) do_reset();
            t_size = vecs[i].ts;
            rd_req = vecs[i].rd;
            wr_send = vecs[i].wr;
            wr_data = vecs[i].wd;
            @(negedge clk);
            chk_cmd($sformatf("vec%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr);
            if (vecs[i].en && vecs[i].we)
                chk($sformatf("vec%0d wdata", i), 64'(mem_wdata), 64'(vecs[i].wdat_e));
            chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd_e);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("drain busy", 64'(busy), 64'd0);
        chk("drain overflow", 64'(overflow), 64'd0);
        next_cycle();

        // Hazard: FIFO holds addr 0 while rd_ptr is 0.
        do_reset();
        t_size = 10'd10;
        for (int c = 0; c < 7; c++) begin
            wr_send = (c == 0);
            wr_data = wdat(8'h77);
            rd_req = (c >= 1 && c < HZ_RESP);
            @(negedge clk);
            if (c == 2) chk_cmd("hazard c2", 1'b1, HZ_FIRST_WE, 8'd0);
            if (c == 3) chk_cmd("hazard c3", 1'b1, !HZ_FIRST_WE, 8'd0);
            if (c == HZ_RESP) chk("hazard rd_data", rd_data, rdv(3'd0, wpay(HZ_PAY_K)));
            next_cycle();
        end
        idle_inputs();

        // Write priority near full: t_size=64, writes first move wr_ptr to 4.
        do_reset();
        t_size = 10'd64;
        for (int c = 0; c < 8; c++) begin
            wr_send = (c < 4);
            wr_data = wdat(8'(16 + c));
            next_cycle();
        end
        for (int c = 0; c < 17; c++) begin
            wr_send = (c < 12);
            wr_data = wdat(8'(32 + c));
            rd_req = (c < 16);
            @(negedge clk);
            if (c == 1)  chk_cmd("prio c1", 1'b1, 1'b0, 8'd0);
            if (c == 2)  chk_cmd("prio c2", 1'b1, 1'b1, 8'd4);
            if (c == 3)  chk("prio rd0", rd_data, rdv(3'd0, wpay(8'h10)));
            if (c == 5)  chk_cmd("prio c5", 1'b1, 1'b0, 8'd1);
            if (c == 9)  chk_cmd("prio c9", 1'b1, 1'b0, 8'd2);
            if (c == 12) chk("prio c12 state", 64'(rd_state), 64'd0);
            if (c == 13) chk_cmd("prio c13", 1'b1, 1'b1, 8'd13);
            if (c == 14) chk_cmd("prio c14", 1'b1, 1'b0, 8'd3);
            if (c == 16) chk("prio rd3", rd_data, rdv(3'd0, wpay(8'h13)));
            next_cycle();
        end
        idle_inputs();

        // rst_addr with queued writes: rd_ptr=1, wr_ptr=3 beforehand.
        do_reset();
        t_size = 10'd64;
        for (int c = 0; c < 12; c++) begin
            wr_send = (c < 3);
            wr_data = wdat(8'(32 + c));
            rd_req = (c == 6);
            next_cycle();
        end
        for (int c = 0; c < 10; c++) begin
            wr_send = (c == 0 || c == 1 || c == 6);
            wr_data = wdat(8'(48 + c));
            rst_addr = (c == 1);
            rd_req = (c >= 3 && c < 7);
            @(negedge clk);
            if (c == 2) chk_cmd("rstaddr c2", 1'b1, 1'b1, 8'd3);
            if (c == 3) chk_cmd("rstaddr c3", 1'b1, 1'b1, 8'd4);
            if (c == 3) chk("rstaddr busy c3", 64'(busy), 64'd1);
            if (c == 4) chk("rstaddr busy c4", 64'(busy), 64'd0);
            if (c == 4) chk_cmd("rstaddr c4", 1'b0, 1'b0, 8'd0);
            if (c == 5) chk_cmd("rstaddr c5", 1'b1, 1'b0, 8'd0);
            if (c == 7) chk("rstaddr rd_data", rd_data, rdv(3'd0, wpay(8'h20)));
            if (c == 8) chk_cmd("rstaddr c8", 1'b1, 1'b1, 8'd0);
            if (c == 8) chk("rstaddr wdata", 64'(mem_wdata), 64'(wpay(8'h36)));
            next_cycle();
        end
        idle_inputs();

        // Asynchronous reset during RD_DATA with a write on the port.
        do_reset();
        t_size = 10'd10;
        rd_req = 1'b1;
        wr_send = 1'b1;
        wr_data = wdat(8'h40);
        next_cycle();
        wr_send = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("async pre state", 64'(rd_state), 64'd2);
        chk_cmd("async pre", 1'b1, 1'b1, 8'd0);
        chk("async pre busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) chk_cmd("async c1", 1'b1, 1'b0, 8'd0);
            if (c == 2) chk("async c2 rd_data", rd_data, 64'd0);
            if (c == 3) chk("async c3 rd_data", rd_data, rdv(3'd0, wpay(8'h36)));
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("final overflow", 64'(overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
